// File: rtl/ntt_job_scheduler_pkg.sv
// Shared types and helpers for the NTT job scheduler.
// Holds the FSM encoding and the clog2 helper.
package ntt_job_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RUN,
    S_RELEASE
  } ntt_state_e;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr,
// wrapping to index 0.
module rr_arbiter
  import ntt_job_scheduler_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        win
);

  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k] && k >= int'(ptr)) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k] && k < int'(ptr)) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Arbitrates NTT wrapper jobs among requesters and
// sequences clear / start / run / release.
module ntt_job_scheduler
  import ntt_job_scheduler_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int LOGN       = 10,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 2 ** (LOGN + 4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_intt,
  input  logic [NREQ-1:0]        req_gs,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        err,
  output logic                   ntt_rst,
  output logic                   ntt_start,
  output logic                   ntt_intt,
  output logic                   ntt_btf_gs,
  input  logic                   ntt_finish,
  output logic                   busy,
  output logic [clog2(NREQ)-1:0] active_id
);

  localparam int IW   = clog2(NREQ);
  localparam int CMAX =
    (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
  localparam int CW   = clog2(CMAX + 1);

  ntt_state_e      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] win;
  logic            rel_ph;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_id = IW'(i);
    end
  end

  assign nxt_ptr = (win_id == IW'(NREQ - 1)) ?
                   '0 : win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      ntt_rst    <= 1'b1;
      ntt_start  <= 1'b0;
      ntt_intt   <= 1'b0;
      ntt_btf_gs <= 1'b0;
      busy       <= 1'b0;
      active_id  <= '0;
      cnt        <= '0;
      ptr        <= '0;
      rel_ph     <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      unique case (state)
        S_IDLE: begin
          ntt_rst <= 1'b0;
          if (|req) begin
            grant      <= win;
            active_id  <= win_id;
            ntt_intt   <= |(req_intt & win);
            ntt_btf_gs <= |(req_gs & win);
            ptr        <= nxt_ptr;
            ntt_rst    <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (cnt == CW'(CLR_CYCLES - 1)) begin
            ntt_rst   <= 1'b0;
            ntt_start <= 1'b1;
            cnt       <= '0;
            state     <= S_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_START: begin
          ntt_start <= 1'b0;
          cnt       <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          // finish beats a same-cycle timeout
          if (ntt_finish) begin
            done   <= grant;
            rel_ph <= 1'b0;
            state  <= S_RELEASE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err    <= grant;
            rel_ph <= 1'b0;
            state  <= S_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!rel_ph) begin
            rel_ph  <= 1'b1;
            ntt_rst <= 1'b1;
            grant   <= '0;
          end else begin
            rel_ph  <= 1'b0;
            ntt_rst <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Directed bench for ntt_job_scheduler: latency,
// round-robin order, timeout, coincidence, reset.
module tb_ntt_job_scheduler;

  localparam int NREQ = 4;
  localparam int TO   = 64;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_intt;
  logic [NREQ-1:0] req_gs;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] err;
  logic            ntt_rst;
  logic            ntt_start;
  logic            ntt_intt;
  logic            ntt_btf_gs;
  logic            ntt_finish;
  logic            busy;
  logic [1:0]      active_id;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  ntt_job_scheduler #(
    .NREQ       (NREQ),
    .LOGN       (2),
    .CLR_CYCLES (2),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_intt   (req_intt),
    .req_gs     (req_gs),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .ntt_rst    (ntt_rst),
    .ntt_start  (ntt_start),
    .ntt_intt   (ntt_intt),
    .ntt_btf_gs (ntt_btf_gs),
    .ntt_finish (ntt_finish),
    .busy       (busy),
    .active_id  (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // kind 0: grant set, 1: ntt_start, 2: busy low
  task automatic wait_sig(input string tag, input int kind);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      tick();
      n++;
      unique case (kind)
        0: ok = (grant != '0);
        1: ok = ntt_start;
        default: ok = !busy;
      endcase
    end
    check(tag, 32'(ok), 1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("done_err_excl", 32'(|(done & err)), 0);
    end
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_intt   = '0;
    req_gs     = '0;
    ntt_finish = 1'b0;
    ticks(3);
    mon_en = 1'b1;
    check("rst_grant", 32'(grant), 0);
    check("rst_ntt_rst", 32'(ntt_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(ntt_start), 0);
    check("rst_id", 32'(active_id), 0);
    rst = 1'b0;
    tick();
    check("idle_ntt_rst", 32'(ntt_rst), 0);

    // single job, requester 2, inverse NTT
    req      = 4'b0100;
    req_intt = 4'b0100;
    tick();
    check("s_grant", 32'(grant), 32'h4);
    check("s_id", 32'(active_id), 2);
    check("s_intt", 32'(ntt_intt), 1);
    check("s_gs", 32'(ntt_btf_gs), 0);
    check("s_rst1", 32'(ntt_rst), 1);
    check("s_busy", 32'(busy), 1);
    tick();
    check("s_rst2", 32'(ntt_rst), 1);
    check("s_start2", 32'(ntt_start), 0);
    tick();
    check("s_rst3", 32'(ntt_rst), 0);
    check("s_start3", 32'(ntt_start), 1);
    tick();
    check("s_start4", 32'(ntt_start), 0);
    req      = '0;
    req_intt = '0;
    ticks(46);
    check("s_run_done", 32'(done), 0);
    ntt_finish = 1'b1;
    tick();
    ntt_finish = 1'b0;
    check("s_done", 32'(done), 32'h4);
    check("s_err", 32'(err), 0);
    check("s_grant_held", 32'(grant), 32'h4);
    tick();
    check("s_rel_rst", 32'(ntt_rst), 1);
    check("s_rel_grant", 32'(grant), 0);
    check("s_done_pulse", 32'(done), 0);
    check("s_intt_hold", 32'(ntt_intt), 1);
    tick();
    check("s_idle_busy", 32'(busy), 0);
    check("s_idle_rst", 32'(ntt_rst), 0);

    // fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_sig("rr_grant_wait", 0);
      check("rr_grant", 32'(grant), 32'(1 << (j % 4)));
      check("rr_id", 32'(active_id), 32'(j % 4));
      wait_sig("rr_start_wait", 1);
      tick();
      ntt_finish = 1'b1;
      tick();
      ntt_finish = 1'b0;
      check("rr_done", 32'(done), 32'(1 << (j % 4)));
      wait_sig("rr_idle_wait", 2);
    end
    req = '0;
    tick();

    // stray finish in IDLE, then through CLEAR; then timeout
    ntt_finish = 1'b1;
    ticks(2);
    check("stray_idle_busy", 32'(busy), 0);
    check("stray_idle_done", 32'(done), 0);
    req    = 4'b0010;
    req_gs = 4'b0010;
    tick();
    check("to_grant", 32'(grant), 32'h2);
    check("to_gs", 32'(ntt_btf_gs), 1);
    tick();
    check("stray_clr_done", 32'(done), 0);
    tick();
    check("stray_start", 32'(ntt_start), 1);
    ntt_finish = 1'b0;
    tick();
    ticks(63);
    check("to_early_err", 32'(err), 0);
    tick();
    check("to_err", 32'(err), 32'h2);
    check("to_done", 32'(done), 0);
    tick();
    check("to_grant_drop", 32'(grant), 0);
    check("to_rel_rst", 32'(ntt_rst), 1);
    tick();

    // finish on the last budgeted RUN cycle
    ticks(2);
    check("co_grant", 32'(grant), 32'h2);
    wait_sig("co_start_wait", 1);
    tick();
    ticks(63);
    ntt_finish = 1'b1;
    tick();
    ntt_finish = 1'b0;
    check("co_done", 32'(done), 32'h2);
    check("co_err", 32'(err), 0);
    req    = '0;
    req_gs = '0;
    wait_sig("co_idle_wait", 2);

    // reset in the middle of RUN
    req      = 4'b1000;
    req_intt = 4'b1000;
    req_gs   = 4'b1000;
    wait_sig("mr_grant_wait", 0);
    check("mr_grant", 32'(grant), 32'h8);
    wait_sig("mr_start_wait", 1);
    tick();
    ticks(10);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    req      = 4'b1111;
    req_intt = '0;
    req_gs   = '0;
    check("mr_grant0", 32'(grant), 0);
    check("mr_rst", 32'(ntt_rst), 1);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_err", 32'(err), 0);
    check("mr_intt", 32'(ntt_intt), 0);
    check("mr_gs", 32'(ntt_btf_gs), 0);
    check("mr_id", 32'(active_id), 0);
    wait_sig("mr_regrant_wait", 0);
    check("mr_ptr0", 32'(grant), 32'h1);
    rst = 1'b1;
    tick();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_job_scheduler.md
NTT_JOB_SCHEDULER -- requirements
Module: ntt_job_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter LOGN, default 10, giving the polynomial size exponent, passed through for timeout sizing.
REQ-003 The block SHALL have parameter CLR_CYCLES, default 2, giving the wrapper-clear pulse length (>=1).
REQ-004 The block SHALL have parameter TIMEOUT, default 2**(LOGN+4), giving the RUN-state cycle budget.
REQ-005 Ports SHALL be: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-006 Ports SHALL be: req in NREQ job request levels; req_intt in NREQ inverse-NTT flag per requester; req_gs in NREQ GS-butterfly flag per requester.
REQ-007 Ports SHALL be: grant out NREQ one-hot owner; done out NREQ one-cycle completion pulse; err out NREQ one-cycle timeout pulse.
REQ-008 Ports SHALL be: ntt_rst out 1 wrapper reset; ntt_start out 1 wrapper start pulse; ntt_intt out 1; ntt_btf_gs out 1; ntt_finish in 1 wrapper finish level.
REQ-009 Ports SHALL be: busy out 1 job in progress; active_id out clog2(NREQ) index of owner.

Function
REQ-010 The FSM SHALL have states IDLE, CLEAR, START, RUN, RELEASE.
REQ-011 In IDLE, if any req is high, the block SHALL pick a winner round-robin, starting from the index after the last winner (index 0 after reset).
REQ-012 On the pick, the block SHALL register grant, active_id, ntt_intt=req_intt[w] and ntt_btf_gs=req_gs[w], then enter CLEAR.
REQ-013 ntt_intt and ntt_btf_gs SHALL hold constant until the next pick.
REQ-014 In CLEAR, ntt_rst SHALL be high for exactly CLR_CYCLES cycles; the block SHALL then enter START.
REQ-015 In START, ntt_start SHALL be high for exactly one cycle; the block SHALL then enter RUN.
REQ-016 Latency: with req sampled high at edge t, grant SHALL be high from t+1, ntt_rst from t+1..t+CLR_CYCLES, and ntt_start at t+CLR_CYCLES+1.
REQ-017 In RUN, a cycle counter SHALL increment each cycle; ntt_finish high SHALL cause done[w] to pulse on the next cycle and entry to RELEASE.
REQ-018 If the counter reaches TIMEOUT-1 in RUN without ntt_finish, err[w] SHALL pulse instead of done[w] and the block SHALL enter RELEASE.
REQ-019 If ntt_finish and timeout coincide, finish SHALL win (done only).
REQ-020 In RELEASE, ntt_rst SHALL be high for one cycle (clearing the wrapper finish level), grant SHALL drop to 0, and the block SHALL return to IDLE.
REQ-021 A requester SHALL NOT be re-granted earlier than one IDLE cycle after RELEASE.
REQ-022 ntt_finish outside RUN SHALL be ignored.
REQ-023 req deassertion during a job SHALL NOT abort it; done or err is still issued to the owner.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 grant SHALL be one-hot or zero at all times, and done|err SHALL never both be high.

Reset
REQ-026 On rst: state=IDLE; grant, done, err, ntt_start, ntt_intt, ntt_btf_gs, busy, active_id and counter SHALL all be 0; ntt_rst SHALL be 1; round-robin pointer SHALL be 0.
REQ-027 rst mid-job SHALL abandon the job with no done or err pulse.
REQ-028 ntt_rst SHALL be low in IDLE after reset release.

Structure
REQ-029 The FSM state encoding and a clog2 helper SHALL live in a shared ntt package.
REQ-030 The round-robin logic SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot winner).
REQ-031 Outputs SHALL be registered.

Verification
REQ-032 Single request: NREQ=4, CLR_CYCLES=2, req[2]=1 with intt=1 at edge 0 -> grant=0100 at 1, ntt_rst cycles 1-2, ntt_start at 3, ntt_intt=1; ntt_finish at 50 -> done[2] at 51, ntt_rst at 52 (RELEASE), IDLE at 53.
REQ-033 Fairness: req=1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Timeout: TIMEOUT=64, no ntt_finish -> err[w] pulse 64 cycles after RUN entry, no done, grant dropped.
REQ-035 Coincidence: ntt_finish asserted on cycle TIMEOUT-1 of RUN -> done only, err stays 0.
REQ-036 Reset mid-RUN: rst at RUN cycle 10 -> next cycle all outputs at reset values, ntt_rst=1, no done/err; pointer=0.
REQ-037 Stray finish: ntt_finish=1 while IDLE or CLEAR -> no done, state unaffected.
